mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory pipeline stage between execute and write-back.
- Latches the execute-to-memory bus and waits for the data-SRAM response of an issued load or store.
- Aligns and merges load data into a per-byte register write strobe, then produces the memory-to-write-back bus consumed by write-back.
- Discards stale SRAM responses after an exception/eret flush, and publishes stall/forward/exception information to the earlier stages.

Parameters:
- CANCEL_W, 2, width of the outstanding-response cancel counter; at most 2^CANCEL_W-1 discarded responses can be pending.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- flush  in  1  exception/eret flush from write-back; kills the stage contents
- ws_allowin  in  1  write-back can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  execute output valid
- es_to_ms_bus  in  `ES_TO_MS_BUS_WD (120)  fields, MSB first:
  - mem_req[119], bd[118], exc_sys[117], eret[116], cp0_wen[115], res_from_cp0[114]
  - cp0_addr[113:106], rf_we[105], dest[104:100], res_from_mem[99]
  - load_op[98:96], rt_value[95:64], alu_result[63:32], pc[31:0]
- ms_to_ws_valid  out  1  output valid
- ms_to_ws_bus  out  `MS_TO_WS_BUS_WD (86)  fields, MSB first:
  - bd, exc_sys, eret, cp0_wen, res_from_cp0, cp0_addr[8], gr_we[4], dest[5], final_result[32], pc[32]
- data_sram_data_ok  in  1  response strobe for the data SRAM
- data_sram_rdata  in  32  response data
- stall_ms_bus  out  10  {any_we, gr_we[4], dest[5]}, qualified by ms_valid
- forward_ms_bus  out  33  {fwd_valid, final_result}
- ms_exc_eret_bus  out  2  {exc_sys&ms_valid, eret&ms_valid}; execute suppresses store requests while either bit is high

Reset domain: one clock; reset is asynchronous and active-low. Ports are clk and resetn.

Behaviour:
- Reset:
  - ms_valid=0, data_got=0, data_buf=0, cancel_cnt=0.
  - Hence ms_to_ws_valid=0, stall_ms_bus any_we=0 and gr_we=0, forward fwd_valid=0, ms_exc_eret_bus=0.
- Handshake:
  - ms_ready_go = !ms_valid | !mem_req | data_got | (data_sram_data_ok & cancel_cnt==0).
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
- Valid register priority, each cycle:
  - flush → ms_valid=0;
  - else if ms_allowin → ms_valid=es_to_ms_valid.
  - The bus register loads when es_to_ms_valid & ms_allowin & !flush.
- Response states: WAIT (ms_valid & mem_req & !data_got) → GOT (data_got=1) → next instruction enters.
  - A data_ok with cancel_cnt==0 in WAIT is captured into data_buf and sets data_got=1, unless the instruction leaves in the same cycle (data is then used combinationally).
  - Entry of a new instruction clears data_got.
  - Total latency is 1 cycle for non-memory instructions; for memory ops it is 1 cycle plus the data_ok delay.
- Cancel counter:
  - On flush while ms_valid & mem_req & !data_got & !data_ok-this-cycle: cancel_cnt+1.
  - Each data_ok arriving while cancel_cnt≠0 is dropped and decrements it.
  - Increment and decrement in the same cycle leave it unchanged.
  - The counter saturates at its maximum (no wrap).
  - Stores use the same wait and cancel path; they produce no register write.
- Load data: rd = data_got ? data_buf : data_sram_rdata; a = alu_result[1:0].
  - load_op 0 lw: rd, we=1111.
  - 1 lb / 2 lbu: byte a, sign-/zero-extended, we=1111.
  - 3 lh / 4 lhu: halfword a[1], sign-/zero-extended, we=1111.
  - 5 lwl: data = rd<<(8*(3-a)); we by a = 0:1000, 1:1100, 2:1110, 3:1111; unwritten bytes taken from rt_value.
  - 6 lwr: data = rd>>(8*a); we by a = 0:1111, 1:0111, 2:0011, 3:0001; unwritten bytes taken from rt_value.
  - 7 is reserved; treat as lw.
- Result and write enable:
  - final_result = res_from_mem ? load_data : alu_result.
  - gr_we = rf_we ? (res_from_mem ? load_we : 1111) : 0000.
  - cp0 fields pass through unchanged; write-back resolves res_from_cp0.
- Forwarding: fwd_valid = ms_valid & ms_ready_go & !res_from_cp0. While a load waits, fwd_valid=0, so ID stalls via stall_ms_bus.
- Reset mid-operation clears all state, including cancel_cnt; responses arriving after reset are not expected.

Test Plan:
- ALU pass-through: alu_result=0x1234_5678, rf_we=1, dest=5, mem_req=0 → next cycle ms_to_ws_valid=1, gr_we=1111, final_result=0x12345678; stall bus any_we=1, dest=5.
- lb with a=3, SRAM returns 0x80FF_0011 after 3 cycles → ms_ready_go low for 3 cycles, then final_result=0xFFFF_FF80; lbu gives 0x0000_0080.
- lwl with a=1, rd=0xAABBCCDD, rt=0x11223344 → gr_we=1100, final_result=0xCCDD3344; lwr with a=2 → gr_we=0011, final_result=0x1122AABB.
- data_ok arrives while ws_allowin=0 → data_got=1, data_buf held; ws_allowin rises 2 cycles later → correct data emitted; the next instruction's data_got starts at 0.
- flush during an outstanding load, then a new load enters and its data_ok arrives → the first data_ok is dropped (cancel_cnt 1→0); the second response is delivered; the flushed load is never emitted.
- Assert resetn low while WAIT with cancel_cnt=1 → all outputs zero immediately (asynchronously), cancel_cnt=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction between execute and write-back,
// waits for its data-SRAM response, aligns load data into a per-byte write
// strobe, and discards responses that belong to flushed instructions.
module mem_stage #(
    parameter int CANCEL_W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         ws_allowin,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [119:0] es_to_ms_bus,
    output logic         ms_to_ws_valid,
    output logic [85:0]  ms_to_ws_bus,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    output logic [9:0]   stall_ms_bus,
    output logic [32:0]  forward_ms_bus,
    output logic [1:0]   ms_exc_eret_bus
);

    localparam logic [CANCEL_W-1:0] CNT_ONE = {{(CANCEL_W-1){1'b0}}, 1'b1};
    localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

    logic                ms_valid;
    logic [119:0]        bus_r;
    logic                data_got;
    logic [31:0]         data_buf;
    logic [CANCEL_W-1:0] cancel_cnt;

    // Latched execute-to-memory fields
    logic        mem_req, bd, exc_sys, eret, cp0_wen, res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        rf_we, res_from_mem;
    logic [4:0]  dest;
    logic [2:0]  load_op;
    logic [31:0] rt_value, alu_result, pc;

    assign mem_req      = bus_r[119];
    assign bd           = bus_r[118];
    assign exc_sys      = bus_r[117];
    assign eret         = bus_r[116];
    assign cp0_wen      = bus_r[115];
    assign res_from_cp0 = bus_r[114];
    assign cp0_addr     = bus_r[113:106];
    assign rf_we        = bus_r[105];
    assign dest         = bus_r[104:100];
    assign res_from_mem = bus_r[99];
    assign load_op      = bus_r[98:96];
    assign rt_value     = bus_r[95:64];
    assign alu_result   = bus_r[63:32];
    assign pc           = bus_r[31:0];

    // Handshake; a response only counts for us once all stale ones are drained
    logic cnt_zero, ms_ready_go, waiting;
    assign cnt_zero       = (cancel_cnt == '0);
    assign waiting        = ms_valid & mem_req & ~data_got;
    assign ms_ready_go    = ~ms_valid | ~mem_req | data_got | (data_sram_data_ok & cnt_zero);
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;

    // Load alignment: raw shifted/extended data plus byte strobe, merged with rt
    logic [31:0] rd, raw, load_data, final_result;
    logic [1:0]  a;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [3:0]  load_we, gr_we;

    assign rd       = data_got ? data_buf : data_sram_rdata;
    assign a        = alu_result[1:0];
    assign sel_byte = rd[{a, 3'b000} +: 8];
    assign sel_half = a[1] ? rd[31:16] : rd[15:0];

    // Select the aligned load value and which destination bytes it replaces
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        raw     = rd;
        load_we = 4'b1111;
        case (load_op)
            3'd1: raw = {{24{sel_byte[7]}}, sel_byte};
            3'd2: raw = {24'b0, sel_byte};
            3'd3: raw = {{16{sel_half[15]}}, sel_half};
            3'd4: raw = {16'b0, sel_half};
            3'd5: begin
                raw = rd << {~a, 3'b000};
                case (a)
                    2'd0:    load_we = 4'b1000;
                    2'd1:    load_we = 4'b1100;
                    2'd2:    load_we = 4'b1110;
                    default: load_we = 4'b1111;
                endcase
            end
            3'd6: begin
                raw = rd >> {a, 3'b000};
                case (a)
                    2'd0:    load_we = 4'b1111;
                    2'd1:    load_we = 4'b0111;
                    2'd2:    load_we = 4'b0011;
                    default: load_we = 4'b0001;
                endcase
            end
            default: raw = rd;
        endcase
        for (int i = 0; i < 4; i++)
            load_data[8*i +: 8] = load_we[i] ? raw[8*i +: 8] : rt_value[8*i +: 8];
    end

    assign final_result = res_from_mem ? load_data : alu_result;
    assign gr_we        = rf_we ? (res_from_mem ? load_we : 4'b1111) : 4'b0000;

    assign ms_to_ws_bus    = {bd, exc_sys, eret, cp0_wen, res_from_cp0, cp0_addr,
                              gr_we, dest, final_result, pc};
    assign stall_ms_bus    = {ms_valid & (|gr_we), ms_valid ? gr_we : 4'b0000, dest};
    assign forward_ms_bus  = {ms_valid & ms_ready_go & ~res_from_cp0, final_result};
    assign ms_exc_eret_bus = {exc_sys & ms_valid, eret & ms_valid};

    // Stage valid: flush wins, otherwise follow upstream when we can accept
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!resetn)         ms_valid <= 1'b0;
        else if (flush)      ms_valid <= 1'b0;
        else if (ms_allowin) ms_valid <= es_to_ms_valid;
    end

    // Bus register captures the incoming instruction
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the bus is reset too so every output reads zero while in reset.
        if (!resetn)                                    bus_r <= '0;
        else if (es_to_ms_valid & ms_allowin & ~flush) bus_r <= es_to_ms_bus;
    end

    // Hold an early response until write-back accepts the instruction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_got <= 1'b0;
            data_buf <= 32'b0;
        end else if (flush | ms_allowin) begin
            data_got <= 1'b0;
        end else if (waiting & data_sram_data_ok & cnt_zero) begin
            data_got <= 1'b1;
            data_buf <= data_sram_rdata;
        end
    end

    // Count responses still owed to flushed instructions; saturates, never wraps
    logic cancel_inc, cancel_dec;
    assign cancel_inc = flush & waiting & ~data_sram_data_ok;
    assign cancel_dec = data_sram_data_ok & ~cnt_zero;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cancel_cnt <= '0;
        else if (cancel_inc & ~cancel_dec & (cancel_cnt != CNT_MAX))
            cancel_cnt <= cancel_cnt + CNT_ONE;
        else if (cancel_dec & ~cancel_inc)
            cancel_cnt <= cancel_cnt - CNT_ONE;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: pass-through, load alignment, write-back
// backpressure, flush cancellation and asynchronous reset.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         flush;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [119:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [85:0]  ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [9:0]   stall_ms_bus;
    logic [32:0]  forward_ms_bus;
    logic [1:0]   ms_exc_eret_bus;

    int n_cmp = 0;
    int n_mis = 0;

    mem_stage #(.CANCEL_W(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .stall_ms_bus      (stall_ms_bus),
        .forward_ms_bus    (forward_ms_bus),
        .ms_exc_eret_bus   (ms_exc_eret_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [119:0] mk_bus(input logic mreq, input logic we, input logic [4:0] dst,
                                            input logic frm_mem, input logic [2:0] lop,
                                            input logic [31:0] rt, input logic [31:0] alu,
                                            input logic [31:0] pcv);
        logic [119:0] b;
        b          = '0;
        b[119]     = mreq;
        b[105]     = we;
        b[104:100] = dst;
        b[99]      = frm_mem;
        b[98:96]   = lop;
        b[95:64]   = rt;
        b[63:32]   = alu;
        b[31:0]    = pcv;
        return b;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [119:0] b);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        next_cycle();
        es_to_ms_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid: got %b want 0", ms_to_ws_valid); end
        n_cmp++; if (stall_ms_bus !== 10'b0) begin n_mis++; $display("FAIL rst_stall: got %h want 000", stall_ms_bus); end
        n_cmp++; if (forward_ms_bus[32] !== 1'b0) begin n_mis++; $display("FAIL rst_fwd: got %b want 0", forward_ms_bus[32]); end
        n_cmp++; if (ms_exc_eret_bus !== 2'b00) begin n_mis++; $display("FAIL rst_exc: got %b want 00", ms_exc_eret_bus); end
        n_cmp++; if (ms_allowin !== 1'b1) begin n_mis++; $display("FAIL rst_allowin: got %b want 1", ms_allowin); end
    endtask

    task automatic test_alu();
        logic [119:0] b;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b0, 1'b1, 5'd5, 1'b0, 3'd0, 32'h0, 32'h1234_5678, 32'h40);
        #1;
        n_cmp++; if (ms_allowin !== 1'b1) begin n_mis++; $display("FAIL alu_allowin: got %b want 1", ms_allowin); end
        next_cycle();
        es_to_ms_valid = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_mis++; $display("FAIL alu_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_to_ws_bus[72:69] !== 4'b1111) begin n_mis++; $display("FAIL alu_we: got %b want 1111", ms_to_ws_bus[72:69]); end
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h1234_5678) begin n_mis++; $display("FAIL alu_result: got %h want 12345678", ms_to_ws_bus[63:32]); end
        n_cmp++; if (stall_ms_bus !== {1'b1, 4'b1111, 5'd5}) begin n_mis++; $display("FAIL alu_stall: got %b want 1111100101", stall_ms_bus); end
        n_cmp++; if (forward_ms_bus !== {1'b1, 32'h1234_5678}) begin n_mis++; $display("FAIL alu_fwd: got %h want 112345678", forward_ms_bus); end
        // cp0 fields pass through, forwarding suppressed for cp0 reads
        b = mk_bus(1'b0, 1'b1, 5'd7, 1'b0, 3'd0, 32'h0, 32'hCAFE_0000, 32'h44);
        b[118] = 1'b1; b[115] = 1'b1; b[114] = 1'b1; b[113:106] = 8'h5A;
        enter(b);
        #1;
        n_cmp++; if (ms_to_ws_bus[85:73] !== {5'b10011, 8'h5A}) begin n_mis++; $display("FAIL cp0_fields: got %b want 1001101011010", ms_to_ws_bus[85:73]); end
        n_cmp++; if (forward_ms_bus[32] !== 1'b0) begin n_mis++; $display("FAIL cp0_fwd: got %b want 0", forward_ms_bus[32]); end
        // no register write
        enter(mk_bus(1'b0, 1'b0, 5'd9, 1'b0, 3'd0, 32'h0, 32'h77, 32'h48));
        #1;
        n_cmp++; if (stall_ms_bus !== {1'b0, 4'b0000, 5'd9}) begin n_mis++; $display("FAIL nowe_stall: got %b want 0000001001", stall_ms_bus); end
        next_cycle();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_mis++; $display("FAIL alu_drain: got %b want 0", ms_to_ws_valid); end
    endtask

    task automatic test_lb();
        enter(mk_bus(1'b1, 1'b1, 5'd3, 1'b1, 3'd1, 32'h0, 32'h1003, 32'h80));
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_mis++; $display("FAIL lb_wait_valid[%0d]: got %b want 0", k, ms_to_ws_valid); end
            n_cmp++; if (ms_allowin !== 1'b0) begin n_mis++; $display("FAIL lb_wait_allowin[%0d]: got %b want 0", k, ms_allowin); end
            n_cmp++; if (forward_ms_bus[32] !== 1'b0) begin n_mis++; $display("FAIL lb_wait_fwd[%0d]: got %b want 0", k, forward_ms_bus[32]); end
            n_cmp++; if (stall_ms_bus[9] !== 1'b1) begin n_mis++; $display("FAIL lb_wait_stall[%0d]: got %b want 1", k, stall_ms_bus[9]); end
            next_cycle();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0011;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk_bus(1'b1, 1'b1, 5'd3, 1'b1, 3'd2, 32'h0, 32'h1003, 32'h84);
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_mis++; $display("FAIL lb_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'hFFFF_FF80) begin n_mis++; $display("FAIL lb_result: got %h want ffffff80", ms_to_ws_bus[63:32]); end
        next_cycle();
        es_to_ms_valid = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h0000_0080) begin n_mis++; $display("FAIL lbu_result: got %h want 00000080", ms_to_ws_bus[63:32]); end
        next_cycle();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_lwl_lwr();
        enter(mk_bus(1'b1, 1'b1, 5'd2, 1'b1, 3'd5, 32'h1122_3344, 32'h2001, 32'h90));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAABB_CCDD;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk_bus(1'b1, 1'b1, 5'd2, 1'b1, 3'd6, 32'h1122_3344, 32'h2002, 32'h94);
        #1;
        n_cmp++; if (ms_to_ws_bus[72:69] !== 4'b1100) begin n_mis++; $display("FAIL lwl_we: got %b want 1100", ms_to_ws_bus[72:69]); end
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'hCCDD_3344) begin n_mis++; $display("FAIL lwl_result: got %h want ccdd3344", ms_to_ws_bus[63:32]); end
        next_cycle();
        es_to_ms_bus = mk_bus(1'b1, 1'b1, 5'd2, 1'b1, 3'd3, 32'h0, 32'h3002, 32'h98);
        #1;
        n_cmp++; if (ms_to_ws_bus[72:69] !== 4'b0011) begin n_mis++; $display("FAIL lwr_we: got %b want 0011", ms_to_ws_bus[72:69]); end
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h1122_AABB) begin n_mis++; $display("FAIL lwr_result: got %h want 1122aabb", ms_to_ws_bus[63:32]); end
        next_cycle();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h8001_7FFF;
        #1;
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'hFFFF_8001) begin n_mis++; $display("FAIL lh_result: got %h want ffff8001", ms_to_ws_bus[63:32]); end
        next_cycle();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_back_to_back();
        ws_allowin = 1'b0;
        enter(mk_bus(1'b1, 1'b1, 5'd4, 1'b1, 3'd0, 32'h0, 32'h100, 32'h300));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_mis++; $display("FAIL bp_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_allowin !== 1'b0) begin n_mis++; $display("FAIL bp_allowin: got %b want 0", ms_allowin); end
        next_cycle();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL bp_held1: got %h want deadbeef", ms_to_ws_bus[63:32]); end
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_mis++; $display("FAIL bp_held_valid: got %b want 1", ms_to_ws_valid); end
        next_cycle();
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 1'b1, 5'd4, 1'b1, 3'd0, 32'h0, 32'h104, 32'h304);
        #1;
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL bp_held2: got %h want deadbeef", ms_to_ws_bus[63:32]); end
        n_cmp++; if (ms_allowin !== 1'b1) begin n_mis++; $display("FAIL bp_release: got %b want 1", ms_allowin); end
        next_cycle();
        es_to_ms_valid = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_got_clear: got %b want 0", ms_to_ws_valid); end
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0102_0304;
        #1;
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h0102_0304) begin n_mis++; $display("FAIL b2b_result: got %h want 01020304", ms_to_ws_bus[63:32]); end
        n_cmp++; if (ms_to_ws_bus[31:0] !== 32'h304) begin n_mis++; $display("FAIL b2b_pc: got %h want 00000304", ms_to_ws_bus[31:0]); end
        next_cycle();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_flush();
        enter(mk_bus(1'b1, 1'b1, 5'd6, 1'b1, 3'd0, 32'h0, 32'h500, 32'h500));
        next_cycle();
        flush = 1'b1;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_mis++; $display("FAIL fl_valid: got %b want 0", ms_to_ws_valid); end
        next_cycle();
        flush          = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 1'b1, 5'd6, 1'b1, 3'd0, 32'h0, 32'h600, 32'h600);
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_mis++; $display("FAIL fl_gap_valid: got %b want 0", ms_to_ws_valid); end
        n_cmp++; if (ms_allowin !== 1'b1) begin n_mis++; $display("FAIL fl_allowin: got %b want 1", ms_allowin); end
        next_cycle();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_BAD0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_mis++; $display("FAIL fl_stale_drop: got %b want 0", ms_to_ws_valid); end
        next_cycle();
        data_sram_rdata = 32'h600D_F00D;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_mis++; $display("FAIL fl_new_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h600D_F00D) begin n_mis++; $display("FAIL fl_new_result: got %h want 600df00d", ms_to_ws_bus[63:32]); end
        n_cmp++; if (ms_to_ws_bus[31:0] !== 32'h600) begin n_mis++; $display("FAIL fl_new_pc: got %h want 00000600", ms_to_ws_bus[31:0]); end
        next_cycle();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [119:0] b;
        enter(mk_bus(1'b1, 1'b1, 5'd8, 1'b1, 3'd0, 32'h0, 32'h700, 32'h700));
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        b = mk_bus(1'b1, 1'b1, 5'd8, 1'b1, 3'd0, 32'h0, 32'h704, 32'h704);
        b[117] = 1'b1;
        enter(b);
        #1;
        n_cmp++; if (ms_exc_eret_bus !== 2'b10) begin n_mis++; $display("FAIL mid_exc: got %b want 10", ms_exc_eret_bus); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_mis++; $display("FAIL mid_rst_valid: got %b want 0", ms_to_ws_valid); end
        n_cmp++; if (ms_to_ws_bus !== 86'b0) begin n_mis++; $display("FAIL mid_rst_bus: got %h want 0", ms_to_ws_bus); end
        n_cmp++; if (stall_ms_bus !== 10'b0) begin n_mis++; $display("FAIL mid_rst_stall: got %h want 000", stall_ms_bus); end
        n_cmp++; if (forward_ms_bus !== 33'b0) begin n_mis++; $display("FAIL mid_rst_fwd: got %h want 0", forward_ms_bus); end
        n_cmp++; if (ms_exc_eret_bus !== 2'b00) begin n_mis++; $display("FAIL mid_rst_exc: got %b want 00", ms_exc_eret_bus); end
        next_cycle();
        resetn = 1'b1;
        enter(mk_bus(1'b1, 1'b1, 5'd8, 1'b1, 3'd0, 32'h0, 32'h708, 32'h708));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1357_9BDF;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_mis++; $display("FAIL mid_cnt_cleared: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h1357_9BDF) begin n_mis++; $display("FAIL mid_result: got %h want 13579bdf", ms_to_ws_bus[63:32]); end
        next_cycle();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        resetn            = 1'b0;
        flush             = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        test_reset();
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        test_alu();
        test_lb();
        test_lwl_lwr();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
